// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer
//   Self-checking driver for a 2-input gate network. It steps {A,B} through
//   00,01,10,11 and holds each vector for SETTLE_CYCLES clocks so the network
//   can settle. F is then sampled for one cycle and compared against the
//   EXPECTED truth table. The per-vector results and an error summary are held
//   until the next accepted start.
//
// Ports
//   clock      in   rising-edge clock
//   reset_L    in   async active-low reset
//   start      in   request a sweep (ignored while busy)
//   dut_f      in   network output F
//   dut_a/b    out  network inputs A/B
//   busy       out  sweep in progress
//   done       out  sweep complete, held until next accepted start
//   pass       out  with done: no mismatching vectors
//   result     out  captured F per vector, index {A,B}
//   err_mask   out  result ^ EXPECTED for swept vectors
//   err_count  out  popcount of err_mask
module gate_tt_sequencer #(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] EXPECTED      = 4'b1001
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       start,
  input  logic       dut_f,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result,
  output logic [3:0] err_mask,
  output logic [2:0] err_count
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    vec;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          mism;

  // start is only honoured while the controller is parked
  assign accept = start && (state == IDLE || state == DONE);
  assign mism   = dut_f ^ EXPECTED[vec];

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)       state_nxt = SETTLE;
      SETTLE:     if (cnt == LAST) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = (vec == 2'b11) ? DONE : SETTLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      vec       <= 2'b00;
      cnt       <= '0;
      result    <= 4'b0000;
      err_mask  <= 4'b0000;
      err_count <= 3'd0;
    end else if (accept) begin
      vec       <= 2'b00;
      cnt       <= '0;
      result    <= 4'b0000;
      err_mask  <= 4'b0000;
      err_count <= 3'd0;
    end else if (state == SETTLE) begin
      cnt <= cnt + 1'b1;
    end else if (state == SAMPLE) begin
      result[vec]   <= dut_f;
      err_mask[vec] <= mism;
      err_count     <= err_count + 3'(mism);
      // vec stays at 11 in DONE so the network inputs hold at 1/1
      if (vec != 2'b11) begin
        vec <= vec + 2'b01;
        cnt <= '0;
      end
    end
  end

  // vec resets to 00 so A/B are 0 in IDLE; it holds 11 in DONE
  assign dut_a = vec[1];
  assign dut_b = vec[0];
  assign busy  = (state == SETTLE) || (state == SAMPLE);
  assign done  = (state == DONE);
  assign pass  = (state == DONE) && (err_mask == 4'b0000);

endmodule
